// File: rtl/instn_cache_pkg.sv
// Shared constants for the set-associative instruction cache:
// replacement policy selectors and the fill state encoding.
package instn_cache_pkg;

    localparam int REPL_FIXED = 0;
    localparam int REPL_RR    = 1;
    localparam int REPL_PLRU  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/cache_repl.sv
// Per-set replacement state: round-robin pointer or tree pseudo-LRU bits.
// Tree node n (heap order, root 1) lives at bit n-1 and points at the LRU side.
module cache_repl
    import instn_cache_pkg::*;
#(
    parameter int SETS   = 4,
    parameter int ASSOC  = 2,
    parameter int POLICY = REPL_PLRU,
    parameter int IW     = 2,
    parameter int WW     = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          touch_en_i,
    input  logic          touch_fill_i,
    input  logic [IW-1:0] touch_idx_i,
    input  logic [WW-1:0] touch_way_i,
    input  logic [IW-1:0] query_idx_i,
    output logic [WW-1:0] victim_o
);

    localparam int LV = $clog2(ASSOC);
    localparam int TW = (ASSOC > 1) ? ASSOC - 1 : 1;

    logic [WW-1:0] ptr_q  [SETS];
    logic [TW-1:0] tree_q [SETS];
    logic [TW-1:0] tree_d;
    logic [WW-1:0] plru_vic;

    always_comb begin
        int            node;
        logic [TW-1:0] t;
        node = 1;
        t    = '0;
        for (int l = 0; l < LV; l++) begin
            t    = tree_q[query_idx_i] >> (node - 1);
            node = 2 * node + (t[0] ? 1 : 0);
        end
        plru_vic = WW'(node - ASSOC);
    end

    // Walk root to leaf, pointing every node on the path away from the touched way.
    always_comb begin
        int            node;
        logic [WW-1:0] w;
        logic [TW-1:0] m;
        tree_d = tree_q[touch_idx_i];
        node   = 1;
        w      = '0;
        m      = '0;
        for (int l = 0; l < LV; l++) begin
            w      = touch_way_i >> (LV - 1 - l);
            m      = TW'(1) << (node - 1);
            tree_d = w[0] ? (tree_d & ~m) : (tree_d | m);
            node   = 2 * node + (w[0] ? 1 : 0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s]  <= '0;
                tree_q[s] <= '0;
            end
        end else if (touch_en_i) begin
            if (POLICY == REPL_RR && touch_fill_i) begin
                ptr_q[touch_idx_i] <= (ptr_q[touch_idx_i] == WW'(ASSOC - 1))
                                    ? '0 : ptr_q[touch_idx_i] + WW'(1);
            end
            if (POLICY == REPL_PLRU) begin
                tree_q[touch_idx_i] <= tree_d;
            end
        end
    end

    always_comb begin
        victim_o = '0;
        if (POLICY == REPL_RR) begin
            victim_o = ptr_q[query_idx_i];
        end else if (POLICY == REPL_PLRU) begin
            victim_o = plru_vic;
        end
    end

endmodule

// File: rtl/instn_cache_cwf.sv
// Set-associative instruction cache with critical-word-first fill,
// early restart of the missed word and a fence.i flush input.
module instn_cache_cwf
    import instn_cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_WIDTH  = 4,
    parameter int ASSOC       = 2,
    parameter int NUM_LINES   = 1024,
    parameter int REPL_POLICY = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] proc_rd_addr,
    input  logic                  proc_rd_en,
    input  logic                  proc_flush,
    output logic [DATA_WIDTH-1:0] proc_rd_data,
    output logic                  proc_rd_hit,
    output logic                  proc_busy,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_valid
);

    localparam int OW   = $clog2(LINE_WIDTH);
    localparam int SETS = NUM_LINES / ASSOC;
    localparam int IW   = $clog2(SETS);
    localparam int TGW  = ADDR_WIDTH - OW - IW;
    localparam int WW   = (ASSOC > 1) ? $clog2(ASSOC) : 1;

    state_e                state_q;
    logic [OW-1:0]         cnt_q;
    logic [ADDR_WIDTH-1:0] miss_addr_q;
    logic [WW-1:0]         vic_q;
    logic                  flush_pend_q;

    logic [SETS-1:0]       valid_q [ASSOC];
    logic [TGW-1:0]        tag_q   [ASSOC][SETS];
    logic [DATA_WIDTH-1:0] data_q  [ASSOC][SETS][LINE_WIDTH];

    logic [TGW-1:0] req_tag, miss_tag;
    logic [IW-1:0]  req_idx, miss_idx;
    logic [OW-1:0]  req_off, miss_off, fill_off;
    logic           hit_any, inv_found, idle_hit, fwd, last_word;
    logic [WW-1:0]  hit_way, vic_d, repl_vic, touch_way;
    logic [IW-1:0]  touch_idx;
    logic           touch_en;

    assign req_tag  = proc_rd_addr[ADDR_WIDTH-1 -: TGW];
    assign req_idx  = proc_rd_addr[OW +: IW];
    assign req_off  = proc_rd_addr[OW-1:0];
    assign miss_tag = miss_addr_q[ADDR_WIDTH-1 -: TGW];
    assign miss_idx = miss_addr_q[OW +: IW];
    assign miss_off = miss_addr_q[OW-1:0];
    assign fill_off = miss_off + cnt_q;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // An empty way always beats the policy's choice.
    always_comb begin
        inv_found = 1'b0;
        vic_d     = repl_vic;
        for (int w = 0; w < ASSOC; w++) begin
            if (!inv_found && !valid_q[w][req_idx]) begin
                inv_found = 1'b1;
                vic_d     = WW'(w);
            end
        end
    end

    assign last_word = (cnt_q == OW'(LINE_WIDTH - 1));
    assign idle_hit  = (state_q == IDLE) && proc_rd_en && hit_any && !proc_flush;
    assign fwd       = (state_q == FILL) && (cnt_q == '0) && mem_rd_valid
                    && proc_rd_en && (proc_rd_addr == miss_addr_q);

    assign proc_rd_hit  = idle_hit || fwd;
    assign proc_rd_data = fwd      ? mem_rd_data
                        : idle_hit ? data_q[hit_way][req_idx][req_off]
                        : '0;
    assign proc_busy    = (state_q == FILL);
    assign mem_rd_en    = (state_q == FILL);
    assign mem_rd_addr  = (state_q == FILL) ? {miss_tag, miss_idx, fill_off}
                        : {proc_rd_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};

    assign touch_en  = idle_hit || ((state_q == FILL) && mem_rd_valid && last_word);
    assign touch_idx = (state_q == FILL) ? miss_idx : req_idx;
    assign touch_way = (state_q == FILL) ? vic_q : hit_way;

    cache_repl #(
        .SETS   (SETS),
        .ASSOC  (ASSOC),
        .POLICY (REPL_POLICY),
        .IW     (IW),
        .WW     (WW)
    ) u_repl (
        .clk          (clk),
        .rstn         (rstn),
        .touch_en_i   (touch_en),
        .touch_fill_i (state_q == FILL),
        .touch_idx_i  (touch_idx),
        .touch_way_i  (touch_way),
        .query_idx_i  (req_idx),
        .victim_o     (repl_vic)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            miss_addr_q  <= '0;
            vic_q        <= '0;
            flush_pend_q <= 1'b0;
            for (int w = 0; w < ASSOC; w++) valid_q[w] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (proc_flush) begin
                        for (int w = 0; w < ASSOC; w++) valid_q[w] <= '0;
                    end else if (proc_rd_en && !hit_any) begin
                        state_q     <= FILL;
                        cnt_q       <= '0;
                        miss_addr_q <= proc_rd_addr;
                        vic_q       <= vic_d;
                    end
                end
                FILL: begin
                    if (proc_flush) flush_pend_q <= 1'b1;
                    if (mem_rd_valid) begin
                        cnt_q <= cnt_q + OW'(1);
                        if (last_word) begin
                            state_q      <= IDLE;
                            flush_pend_q <= 1'b0;
                            if (flush_pend_q || proc_flush) begin
                                for (int w = 0; w < ASSOC; w++) valid_q[w] <= '0;
                            end else begin
                                valid_q[vic_q][miss_idx] <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && state_q == FILL && mem_rd_valid) begin
            data_q[vic_q][miss_idx][fill_off] <= mem_rd_data;
            if (last_word) tag_q[vic_q][miss_idx] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_instn_cache_cwf.sv
// Directed bench: PLRU and round-robin caches driven in lockstep through
// cold fill, stalls, flushes, reset mid-fill and eviction.
module tb_instn_cache_cwf;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] addr;
    logic        en, flush, mvalid;
    logic [31:0] data_a, data_b, mdata_a, mdata_b;
    logic        hit_a, hit_b, busy_a, busy_b, men_a, men_b;
    logic [15:0] maddr_a, maddr_b;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign mdata_a = 32'hA000 + 32'(maddr_a);
    assign mdata_b = 32'hA000 + 32'(maddr_b);

    instn_cache_cwf #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .LINE_WIDTH(4),
        .ASSOC(2), .NUM_LINES(8), .REPL_POLICY(2)
    ) u_plru (
        .clk(clk), .rstn(rstn),
        .proc_rd_addr(addr), .proc_rd_en(en), .proc_flush(flush),
        .proc_rd_data(data_a), .proc_rd_hit(hit_a), .proc_busy(busy_a),
        .mem_rd_addr(maddr_a), .mem_rd_en(men_a),
        .mem_rd_data(mdata_a), .mem_rd_valid(mvalid)
    );

    instn_cache_cwf #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .LINE_WIDTH(4),
        .ASSOC(2), .NUM_LINES(8), .REPL_POLICY(1)
    ) u_rr (
        .clk(clk), .rstn(rstn),
        .proc_rd_addr(addr), .proc_rd_en(en), .proc_flush(flush),
        .proc_rd_data(data_b), .proc_rd_hit(hit_b), .proc_busy(busy_b),
        .mem_rd_addr(maddr_b), .mem_rd_en(men_b),
        .mem_rd_data(mdata_b), .mem_rd_valid(mvalid)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Probe without letting a miss start: en drops before the edge.
    task automatic look(input string tag, input logic [15:0] a,
                        input logic ea, input logic eb);
        addr = a;
        en   = 1'b1;
        @(negedge clk);
        chk({tag, "_hitA"}, 32'(hit_a), 32'(ea));
        if (ea) chk({tag, "_datA"}, data_a, 32'hA000 + 32'(a));
        chk({tag, "_hitB"}, 32'(hit_b), 32'(eb));
        en = 1'b0;
        tick;
    endtask

    task automatic do_fill(input logic [15:0] a, input int st, input int sl,
                           input int fl, output int bc);
        int          n, c;
        logic [15:0] ex;
        n      = 0;
        c      = 0;
        addr   = a;
        en     = 1'b1;
        flush  = 1'b0;
        mvalid = 1'b1;
        @(negedge clk);
        chk("miss_hit", 32'(hit_a), 0);
        chk("miss_busy", 32'({busy_a, busy_b, men_a}), 0);
        chk("idle_maddr", 32'(maddr_a), 32'({a[15:2], 2'b00}));
        tick;
        while (n < 4 && c < 40) begin
            mvalid = !(c >= st && c < st + sl);
            flush  = (c == fl);
            ex     = {a[15:2], a[1:0] + n[1:0]};
            @(negedge clk);
            chk("fill_busy", 32'({busy_a, busy_b, men_a, men_b}), 32'hF);
            chk("fill_maddr", 32'(maddr_a), 32'(ex));
            chk("fill_hit", 32'(hit_a), (n == 0 && mvalid) ? 1 : 0);
            if (n == 0 && mvalid) chk("fwd_data", data_a, 32'hA000 + 32'(a));
            tick;
            flush = 1'b0;
            if (mvalid) n++;
            c++;
        end
        mvalid = 1'b1;
        chk("fill_words", n, 4);
        bc = c;
        en = 1'b0;
        @(negedge clk);
        chk("fill_done_busy", 32'({busy_a, busy_b}), 0);
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        rstn   = 1'b0;
        addr   = 16'h0012;
        en     = 1'b0;
        flush  = 1'b0;
        mvalid = 1'b0;
        tick;
        tick;
        @(negedge clk);
        chk("rst_hit", 32'(hit_a), 0);
        chk("rst_data", data_a, 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_men", 32'(men_a), 0);
        chk("rst_maddr", 32'(maddr_a), 32'h0010);
        rstn = 1'b1;
        tick;

        do_fill(16'h0012, 99, 0, -1, bc);
        chk("cold_cycles", bc, 4);
        for (int i = 0; i < 4; i++) look("cold", 16'h0010 + 16'(i), 1'b1, 1'b1);

        do_fill(16'h0024, 2, 3, -1, bc);
        chk("stall_cycles", bc, 7);
        look("stall26", 16'h0026, 1'b1, 1'b1);
        look("stall24", 16'h0024, 1'b1, 1'b1);

        addr  = 16'h0012;
        en    = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_hit", 32'(hit_a), 0);
        tick;
        flush = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        chk("flush_nomiss", 32'(busy_a), 0);
        tick;
        look("flush12", 16'h0012, 1'b0, 1'b0);
        look("flush24", 16'h0024, 1'b0, 1'b0);

        do_fill(16'h0012, 99, 0, 2, bc);
        chk("flfill_cycles", bc, 4);
        look("flfill12", 16'h0012, 1'b0, 1'b0);

        do_fill(16'h0024, 99, 0, -1, bc);
        addr   = 16'h0012;
        en     = 1'b1;
        mvalid = 1'b1;
        tick;
        tick;
        tick;
        rstn = 1'b0;
        en   = 1'b0;
        @(negedge clk);
        chk("mid_maddr", 32'(maddr_a), 32'h0010);
        tick;
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_men", 32'({men_a, men_b}), 0);
        chk("mid_busy", 32'({busy_a, busy_b}), 0);
        tick;
        look("mid12", 16'h0012, 1'b0, 1'b0);
        look("mid24", 16'h0024, 1'b0, 1'b0);

        do_fill(16'h0000, 99, 0, -1, bc);
        do_fill(16'h0040, 99, 0, -1, bc);
        addr = 16'h0000;
        en   = 1'b1;
        @(negedge clk);
        chk("ev_hitA", 32'(hit_a), 1);
        chk("ev_hitB", 32'(hit_b), 1);
        chk("ev_data", data_a, 32'hA000);
        tick;
        en = 1'b0;
        do_fill(16'h0080, 99, 0, -1, bc);
        look("ev00", 16'h0000, 1'b1, 1'b0);
        look("ev40", 16'h0040, 1'b0, 1'b1);
        look("ev80", 16'h0080, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
